// File: rtl/cic_comb_if.sv
// Sample/result bundle of the CIC comb section: one integrator word in, one comb word out.
interface cic_comb_if #(
    parameter int WIDTH = 64
);
    logic             en_i;
    logic             clr_i;
    logic [1:0]       sel_i;
    logic             diff_delay_i;
    logic [WIDTH-1:0] data_i;
    logic [WIDTH-1:0] data_o;
    logic [1:0]       ch_o;
    logic             valid_o;
    logic             primed_o;

    modport master (
        output en_i, clr_i, sel_i, diff_delay_i, data_i,
        input  data_o, ch_o, valid_o, primed_o
    );

    modport slave (
        input  en_i, clr_i, sel_i, diff_delay_i, data_i,
        output data_o, ch_o, valid_o, primed_o
    );
endinterface

// File: rtl/cic_comb.sv
// Four-channel time-multiplexed CIC comb: y = x[n] - x[n-M], M in {1,2}, one registered result
// per accepted sample, tagged with its channel and whether the delay line was full.
module cic_comb #(
    parameter int WIDTH = 64
) (
    input  logic      clk_i,
    input  logic      rst_i,
    cic_comb_if.slave bus
);
    logic [WIDTH-1:0] d1_q [4];
    logic [WIDTH-1:0] d1_d [4];
    logic [WIDTH-1:0] d2_q [4];
    logic [WIDTH-1:0] d2_d [4];
    logic [1:0]       fill_q [4];
    logic [1:0]       fill_d [4];

    logic [WIDTH-1:0] data_q, data_d;
    logic [1:0]       ch_q, ch_d;
    logic             valid_q, valid_d;
    logic             primed_q, primed_d;

    logic [WIDTH-1:0] past_sample;
    logic [1:0]       fill_cur;

    always_comb begin
        d1_d     = d1_q;
        d2_d     = d2_q;
        fill_d   = fill_q;
        data_d   = data_q;
        ch_d     = ch_q;
        primed_d = primed_q;
        valid_d  = 1'b0;

        past_sample = bus.diff_delay_i ? d2_q[bus.sel_i] : d1_q[bus.sel_i];
        fill_cur    = fill_q[bus.sel_i];

        if (bus.clr_i) begin
            for (int c = 0; c < 4; c++) begin
                d1_d[c]   = '0;
                d2_d[c]   = '0;
                fill_d[c] = 2'd0;
            end
            data_d   = '0;
            ch_d     = 2'd0;
            primed_d = 1'b0;
        end else if (bus.en_i) begin
            // modulo-2^WIDTH wrap is how the CIC cancels integrator overflow
            data_d   = bus.data_i - past_sample;
            ch_d     = bus.sel_i;
            valid_d  = 1'b1;
            primed_d = bus.diff_delay_i ? (fill_cur >= 2'd2) : (fill_cur >= 2'd1);
            d2_d[bus.sel_i]   = d1_q[bus.sel_i];
            d1_d[bus.sel_i]   = bus.data_i;
            fill_d[bus.sel_i] = (fill_cur == 2'd2) ? 2'd2 : fill_cur + 2'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int c = 0; c < 4; c++) begin
                d1_q[c]   <= '0;
                d2_q[c]   <= '0;
                fill_q[c] <= 2'd0;
            end
            data_q   <= '0;
            ch_q     <= 2'd0;
            valid_q  <= 1'b0;
            primed_q <= 1'b0;
        end else begin
            d1_q     <= d1_d;
            d2_q     <= d2_d;
            fill_q   <= fill_d;
            data_q   <= data_d;
            ch_q     <= ch_d;
            valid_q  <= valid_d;
            primed_q <= primed_d;
        end
    end

    assign bus.data_o   = data_q;
    assign bus.ch_o     = ch_q;
    assign bus.valid_o  = valid_q;
    assign bus.primed_o = primed_q;
endmodule

// File: tb/tb_cic_comb.sv
// Directed bench for cic_comb; each observation packs {valid, ch, primed, data} into 68 bits.
module tb_cic_comb;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    cic_comb_if #(.WIDTH(64)) bus ();

    cic_comb #(.WIDTH(64)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [67:0] obs;
    assign obs = {bus.valid_o, bus.ch_o, bus.primed_o, bus.data_o};

    // drive one cycle of inputs, then sample 1 time unit after the edge
    task automatic step(input logic en, input logic clr, input logic [1:0] sel,
                        input logic m2, input logic [63:0] d);
        bus.en_i = en;
        bus.clr_i = clr;
        bus.sel_i = sel;
        bus.diff_delay_i = m2;
        bus.data_i = d;
        @(posedge clk);
        #1;
        bus.en_i = 1'b0;
        bus.clr_i = 1'b0;
    endtask

    task automatic clear_all();
        step(1'b0, 1'b1, 2'd0, 1'b0, 64'd0);
    endtask

    task automatic test_reset();
        tests++;
        if (obs !== 68'd0) begin
            fails++;
            $display("FAIL reset_initial: got %h expected %h", obs, 68'd0);
        end
        #3 rst = 1'b0;
        step(1'b1, 1'b0, 2'd1, 1'b0, 64'd5);
        step(1'b1, 1'b0, 2'd1, 1'b0, 64'd9);
        tests++;
        if (obs !== {1'b1, 2'd1, 1'b1, 64'd4}) begin
            fails++;
            $display("FAIL reset_prestream: got %h expected %h", obs, {1'b1, 2'd1, 1'b1, 64'd4});
        end
        rst = 1'b1;
        #1;
        tests++;
        if (obs !== 68'd0) begin
            fails++;
            $display("FAIL reset_async: got %h expected %h", obs, 68'd0);
        end
        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 2'd1, 1'b0, 64'd0);
            tests++;
            if (bus.valid_o !== 1'b0) begin
                fails++;
                $display("FAIL reset_idle_valid[%0d]: got %b expected 0", i, bus.valid_o);
            end
        end
        step(1'b1, 1'b0, 2'd1, 1'b0, 64'd20);
        tests++;
        if (obs !== {1'b1, 2'd1, 1'b0, 64'd20}) begin
            fails++;
            $display("FAIL reset_state_cleared: got %h expected %h", obs, {1'b1, 2'd1, 1'b0, 64'd20});
        end
    endtask

    task automatic test_m1();
        logic [63:0] din  [3] = '{64'd10, 64'd25, 64'd45};
        logic [67:0] expv [3] = '{{1'b1, 2'd0, 1'b0, 64'd10},
                                  {1'b1, 2'd0, 1'b1, 64'd15},
                                  {1'b1, 2'd0, 1'b1, 64'd20}};
        clear_all();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 2'd0, 1'b0, din[i]);
            tests++;
            if (obs !== expv[i]) begin
                fails++;
                $display("FAIL m1_ch0[%0d]: got %h expected %h", i, obs, expv[i]);
            end
        end
    endtask

    task automatic test_m2_interleave();
        logic [1:0]  sel  [5] = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd0};
        logic [63:0] din  [5] = '{64'd100, 64'd7, 64'd130, 64'd9, 64'd170};
        logic [67:0] expv [5] = '{{1'b1, 2'd0, 1'b0, 64'd100},
                                  {1'b1, 2'd1, 1'b0, 64'd7},
                                  {1'b1, 2'd0, 1'b0, 64'd130},
                                  {1'b1, 2'd1, 1'b0, 64'd9},
                                  {1'b1, 2'd0, 1'b1, 64'd70}};
        clear_all();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, sel[i], 1'b1, din[i]);
            tests++;
            if (obs !== expv[i]) begin
                fails++;
                $display("FAIL m2_interleave[%0d]: got %h expected %h", i, obs, expv[i]);
            end
        end
    endtask

    task automatic test_wrap();
        logic [63:0] din  [2] = '{64'hFFFF_FFFF_FFFF_FFF0, 64'h10};
        logic [67:0] expv [2] = '{{1'b1, 2'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF0},
                                  {1'b1, 2'd0, 1'b1, 64'h20}};
        clear_all();
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b0, 2'd0, 1'b0, din[i]);
            tests++;
            if (obs !== expv[i]) begin
                fails++;
                $display("FAIL wrap[%0d]: got %h expected %h", i, obs, expv[i]);
            end
        end
    endtask

    task automatic test_clear_priority();
        logic       en   [4] = '{1'b1, 1'b1, 1'b1, 1'b1};
        logic       clr  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [63:0] din [4] = '{64'd5, 64'd8, 64'd50, 64'd60};
        logic [67:0] expv [4] = '{{1'b1, 2'd2, 1'b0, 64'd5},
                                  {1'b1, 2'd2, 1'b1, 64'd3},
                                  68'd0,
                                  {1'b1, 2'd2, 1'b0, 64'd60}};
        clear_all();
        for (int i = 0; i < 4; i++) begin
            step(en[i], clr[i], 2'd2, 1'b0, din[i]);
            tests++;
            if (obs !== expv[i]) begin
                fails++;
                $display("FAIL clear_priority[%0d]: got %h expected %h", i, obs, expv[i]);
            end
        end
    endtask

    // gaps between samples must hold data/ch/primed and drop valid
    task automatic test_delay_switch();
        logic       en   [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic       m2   [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [63:0] din [7] = '{64'd1, 64'd99, 64'd3, 64'd77, 64'd6, 64'd55, 64'd10};
        logic [67:0] expv [7] = '{{1'b1, 2'd3, 1'b0, 64'd1},
                                  {1'b0, 2'd3, 1'b0, 64'd1},
                                  {1'b1, 2'd3, 1'b1, 64'd2},
                                  {1'b0, 2'd3, 1'b1, 64'd2},
                                  {1'b1, 2'd3, 1'b1, 64'd3},
                                  {1'b0, 2'd3, 1'b1, 64'd3},
                                  {1'b1, 2'd3, 1'b1, 64'd7}};
        clear_all();
        for (int i = 0; i < 7; i++) begin
            step(en[i], 1'b0, 2'd3, m2[i], din[i]);
            tests++;
            if (obs !== expv[i]) begin
                fails++;
                $display("FAIL delay_switch[%0d]: got %h expected %h", i, obs, expv[i]);
            end
        end
    endtask

    initial begin
        bus.en_i = 1'b0;
        bus.clr_i = 1'b0;
        bus.sel_i = 2'd0;
        bus.diff_delay_i = 1'b0;
        bus.data_i = 64'd0;
        #2;
        test_reset();
        test_m1();
        test_m2_interleave();
        test_wrap();
        test_clear_priority();
        test_delay_switch();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
